// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial_tx asynchronous-frame transmitter.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic TX_IDLE_LEVEL = 1'b1;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Handshake and line signals of the serial transmitter, seen from driver and transmitter.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              start;
  logic              ready;
  logic              tx;
  logic              done;

  modport master (output data, output start, input ready, input tx, input done);
  modport slave  (input data, input start, output ready, output tx, output done);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module serial_tx_bit_timer
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_clear,
  output logic o_tick
);
  localparam int            CW   = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;

  // Free-running bit counter, held at zero while cleared, wrapping at the period end.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_cnt <= {CW{1'b0}};
    end else if (i_clear || (r_cnt == LAST)) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_clear;

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits LSB first,
// optional parity bit, stop bit; each held for CLKS_PER_BIT clocks.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  serial_tx_if.slave  bus
);
  localparam int            IW          = cnt_w(DATA_W);
  localparam logic [IW-1:0] LAST_BIT    = IW'(DATA_W - 1);
  localparam logic [IW-1:0] IDX_ONE     = IW'(1);
  localparam logic          PAR_ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  state_t            r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IW-1:0]     r_bit_idx;
  logic              r_parity;
  logic              r_tx;
  logic              r_done;
  logic              w_tick;
  logic              w_clear;
  logic [DATA_W-1:0] w_shift_next;

  // The timer is held cleared while idle, so it restarts from zero on the accept edge.
  assign w_clear      = (r_state == ST_IDLE);
  assign w_shift_next = r_shift >> 1;

  serial_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_clear  (w_clear),
    .o_tick   (w_tick)
  );

  // Frame FSM; r_tx is loaded with the level of the slot being entered.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state   <= ST_IDLE;
      r_tx      <= TX_IDLE_LEVEL;
      r_done    <= 1'b0;
      r_shift   <= {DATA_W{1'b0}};
      r_bit_idx <= {IW{1'b0}};
      r_parity  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx <= TX_IDLE_LEVEL;
          if (bus.start) begin
            r_shift   <= bus.data;
            r_parity  <= (^bus.data) ^ PAR_ODD_BIT;
            r_bit_idx <= {IW{1'b0}};
            r_tx      <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift <= w_shift_next;
            if (r_bit_idx == LAST_BIT) begin
              r_bit_idx <= {IW{1'b0}};
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= TX_IDLE_LEVEL;
                r_state <= ST_STOP;
              end
            end else begin
              r_bit_idx <= r_bit_idx + IDX_ONE;
              r_tx      <= w_shift_next[0];
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_tx    <= TX_IDLE_LEVEL;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_tx    <= TX_IDLE_LEVEL;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx    <= TX_IDLE_LEVEL;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ready = (r_state == ST_IDLE);
  assign bus.tx    = r_tx;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (no parity, even parity, odd parity) checked
// cycle by cycle against a slot-based frame model.
module tb_serial_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] data_s [3];
  logic          start_s[3];
  logic          tx_o   [3];
  logic          ready_o[3];
  logic          done_o [3];

  serial_tx_if #(.DATA_W(DW)) bus0 ();
  serial_tx_if #(.DATA_W(DW)) bus1 ();
  serial_tx_if #(.DATA_W(DW)) bus2 ();

  assign bus0.data = data_s[0];  assign bus0.start = start_s[0];
  assign bus1.data = data_s[1];  assign bus1.start = start_s[1];
  assign bus2.data = data_s[2];  assign bus2.start = start_s[2];
  assign tx_o[0] = bus0.tx;  assign ready_o[0] = bus0.ready;  assign done_o[0] = bus0.done;
  assign tx_o[1] = bus1.tx;  assign ready_o[1] = bus1.ready;  assign done_o[1] = bus1.done;
  assign tx_o[2] = bus2.tx;  assign ready_o[2] = bus2.ready;  assign done_o[2] = bus2.done;

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0))
    u_dut_np (.i_clk(clk), .i_resetn(resetn), .bus(bus0));
  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0))
    u_dut_pe (.i_clk(clk), .i_resetn(resetn), .bus(bus1));
  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1))
    u_dut_po (.i_clk(clk), .i_resetn(resetn), .bus(bus2));

  // Instance 0 has no parity, 1 even parity, 2 odd parity.
  function automatic int has_par(input int k);
    return (k > 0) ? 1 : 0;
  endfunction

  function automatic int frame_len(input int k);
    return (DW + 2 + has_par(k)) * CPB;
  endfunction

  // Line level c cycles after the accept edge: slot 0 start, then data LSB first, parity, stop.
  function automatic logic exp_tx(input int k, input logic [DW-1:0] d, input int c);
    int slot;
    slot = c / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return d[slot-1];
    if (has_par(k) == 1 && slot == DW + 1) return (^d) ^ (k == 2);
    return 1'b1;
  endfunction

  task automatic check_idle(input int k, input string tag);
    checks++;
    if (tx_o[k] !== 1'b1 || ready_o[k] !== 1'b1 || done_o[k] !== 1'b0) begin
      errors++;
      $display("FAIL %s dut%0d: tx=%b ready=%b done=%b, required tx=1 ready=1 done=0",
               tag, k, tx_o[k], ready_o[k], done_o[k]);
    end
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (n < 200 && ready_o[k] !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready_o[k] !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout dut%0d: ready=%b after %0d cycles, required 1", k, ready_o[k], n);
    end
  endtask

  // Presents data with Start before an edge; returns just after the accept edge.
  task automatic start_frame(input int k, input logic [DW-1:0] d, input bit hold);
    wait_ready(k);
    data_s[k]  = d;
    start_s[k] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_s[k] = 1'b0;
  endtask

  // Checks a whole frame from just after its accept edge through the Done edge.
  task automatic check_frame(input int k, input logic [DW-1:0] d, input bit noisy,
                             output int done_cyc);
    int len;
    len = frame_len(k);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      checks++;
      if (tx_o[k] !== exp_tx(k, d, c) || ready_o[k] !== 1'b0 || done_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL frame dut%0d d=%h c=%0d: tx=%b ready=%b done=%b, required tx=%b ready=0 done=0",
                 k, d, c, tx_o[k], ready_o[k], done_o[k], exp_tx(k, d, c));
      end
      if (noisy) begin
        data_s[k]  = DW'($urandom);
        start_s[k] = (c == 9);
      end
    end
    @(negedge clk);
    done_cyc = cyc;
    checks++;
    if (tx_o[k] !== 1'b1 || ready_o[k] !== 1'b1 || done_o[k] !== 1'b1) begin
      errors++;
      $display("FAIL frame_end dut%0d d=%h: tx=%b ready=%b done=%b, required tx=1 ready=1 done=1",
               k, d, tx_o[k], ready_o[k], done_o[k]);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      data_s[k]  = '0;
      start_s[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) check_idle(k, "reset_idle");
    end
  endtask

  task automatic test_basic();
    int dc;
    start_frame(0, 8'hA5, 1'b0);
    check_frame(0, 8'hA5, 1'b0, dc);
  endtask

  task automatic test_parity();
    int dc;
    start_frame(1, 8'h07, 1'b0);
    check_frame(1, 8'h07, 1'b0, dc);
    start_frame(2, 8'h07, 1'b0);
    check_frame(2, 8'h07, 1'b0, dc);
  endtask

  task automatic test_busy_ignore();
    int dc;
    start_frame(0, 8'h3C, 1'b0);
    check_frame(0, 8'h3C, 1'b1, dc);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle(0, "no_queued_frame");
    end
  endtask

  task automatic test_back_to_back(input int k, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int d_a, d_b;
    start_frame(k, d0, 1'b1);
    data_s[k] = d1;
    check_frame(k, d0, 1'b0, d_a);
    @(posedge clk);
    #1 start_s[k] = 1'b0;
    check_frame(k, d1, 1'b0, d_b);
    checks++;
    if (d_b - d_a !== frame_len(k) + 1) begin
      errors++;
      $display("FAIL done_spacing dut%0d: %0d cycles, required %0d", k, d_b - d_a, frame_len(k) + 1);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    logic [DW-1:0] d;
    d = DW'($urandom);
    start_frame(0, d, 1'b0);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      checks++;
      if (tx_o[0] !== exp_tx(0, d, c)) begin
        errors++;
        $display("FAIL pre_reset c=%0d: tx=%b, required %b", c, tx_o[0], exp_tx(0, d, c));
      end
    end
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle(0, "mid_reset");
    end
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_idle(0, "post_reset");
    end
    d = DW'($urandom);
    start_frame(0, d, 1'b0);
    check_frame(0, d, 1'b0, dc);
  endtask

  task automatic test_random();
    int dc, k;
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        test_back_to_back(k, DW'($urandom), DW'($urandom));
      end else begin
        logic [DW-1:0] d;
        d = DW'($urandom);
        start_frame(k, d, 1'b0);
        check_frame(k, d, ($urandom_range(0, 1) == 1), dc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_busy_ignore();
    test_back_to_back(0, 8'h00, 8'hFF);
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
